// File: rtl/dct_coef_mem_writer.sv
// -----------------------------------------------------------------------------
// dct_coef_mem_writer
//
// Write-side sink of the 2D DCT datapath. Accepts one packed vector of N_COEF
// coefficients per handshake into a two-entry ping-pong buffer and serializes
// each buffered vector into the coefficient memory, one CW-bit word per
// address, coef 0 first, with no bubbles between consecutive vectors.
// A frame is NUM_VEC vectors; after its last word the block parks in DONE
// until the next start pulse.
//
// Optional feature (macro DCT_WR_CHKSUM_EN): adds a 16-bit running checksum
// of every written word (sign-extended to 16 bits, summed mod 2^16).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   start      in   begin/restart a frame (one-cycle pulse, wins over in_valid)
//   in_valid   in   in_coef holds a valid vector
//   in_ready   out  vector accepted when in_valid & in_ready (registered)
//   in_coef    in   packed vector, coef k = in_coef[k*CW +: CW]
//   mem_we     out  memory write enable
//   mem_addr   out  memory word address
//   mem_wdata  out  memory write data
//   busy       out  frame in progress (RUN)
//   done       out  frame complete (DONE, level)
//   vec_cnt    out  vectors fully written this frame
//   chksum     out  running word checksum (only with DCT_WR_CHKSUM_EN)
// -----------------------------------------------------------------------------
module dct_coef_mem_writer #(
    parameter int N_COEF  = 16,
    parameter int CW      = 11,
    parameter int AW      = 13,
    parameter int NUM_VEC = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_COEF*CW-1:0]   in_coef,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [CW-1:0]          mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          vec_cnt
`ifdef DCT_WR_CHKSUM_EN
    ,
    output logic [15:0]            chksum
`endif
);

    localparam int              KW       = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [KW-1:0]   K_LAST   = KW'(N_COEF - 1);
    localparam logic [AW-1:0]   VEC_LAST = AW'(NUM_VEC - 1);
    localparam logic [AW:0]     ACC_MAX  = (AW+1)'(NUM_VEC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;

    // Ping-pong storage: wr_sel_r is the slot the next accepted vector lands
    // in, rd_sel_r is the slot currently being serialized.
    logic [N_COEF*CW-1:0]   vec_buf_r [2];
    logic                   wr_sel_r;
    logic                   rd_sel_r;
    logic [1:0]             occ_r;
    logic [1:0]             occ_nxt_s;
    // Vectors accepted this frame; one extra bit so NUM_VEC itself fits.
    logic [AW:0]            acc_r;
    logic [AW:0]            acc_nxt_s;
    logic [KW-1:0]          word_idx_r;
    // Next address to be written; mem_addr shows it whenever no write is out.
    logic [AW-1:0]          addr_cnt_r;

    logic                   accept_s;
    logic                   ser_we_s;
    logic                   last_word_s;
    logic                   frame_end_s;
    logic                   in_ready_nxt_s;
    logic [CW-1:0]          word_s;

`ifdef DCT_WR_CHKSUM_EN
    // Sign-extend one coefficient word to the 16-bit checksum width.
    function automatic logic [15:0] sext16(input logic [CW-1:0] w);
        return 16'($signed(w));
    endfunction
`endif

    // Handshake, serializer and next-state decode.
    always_comb begin
        accept_s    = in_valid & in_ready & ~start;
        ser_we_s    = (state_r == S_RUN) && (occ_r != 2'd0) && !start;
        last_word_s = ser_we_s && (word_idx_r == K_LAST);
        frame_end_s = last_word_s && (vec_cnt == VEC_LAST);
        word_s      = vec_buf_r[rd_sel_r][word_idx_r*CW +: CW];

        // Accept and free in the same cycle leave occupancy unchanged.
        if (start) begin
            occ_nxt_s = 2'd0;
        end else if (accept_s && !last_word_s) begin
            occ_nxt_s = occ_r + 2'd1;
        end else if (!accept_s && last_word_s) begin
            occ_nxt_s = occ_r - 2'd1;
        end else begin
            occ_nxt_s = occ_r;
        end

        if (start) begin
            acc_nxt_s = {(AW+1){1'b0}};
        end else if (accept_s) begin
            acc_nxt_s = acc_r + (AW+1)'(1'b1);
        end else begin
            acc_nxt_s = acc_r;
        end

        if (start) begin
            state_nxt_s = S_RUN;
        end else begin
            case (state_r)
                S_IDLE:  state_nxt_s = S_IDLE;
                S_RUN:   state_nxt_s = frame_end_s ? S_DONE : S_RUN;
                S_DONE:  state_nxt_s = S_DONE;
                default: state_nxt_s = S_IDLE;
            endcase
        end

        // in_ready is registered from next-state values, so it never depends
        // on in_valid combinationally.
        in_ready_nxt_s = (state_nxt_s == S_RUN) && (occ_nxt_s < 2'd2) &&
                         (acc_nxt_s < ACC_MAX);
    end

    // Vector buffer capture; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            vec_buf_r[wr_sel_r] <= in_coef;
        end
    end

    // Frame FSM, buffer bookkeeping and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            wr_sel_r   <= 1'b0;
            rd_sel_r   <= 1'b0;
            occ_r      <= 2'd0;
            acc_r      <= {(AW+1){1'b0}};
            word_idx_r <= {KW{1'b0}};
            addr_cnt_r <= {AW{1'b0}};
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {AW{1'b0}};
            mem_wdata  <= {CW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_cnt    <= {AW{1'b0}};
`ifdef DCT_WR_CHKSUM_EN
            chksum     <= 16'd0;
`endif
        end else if (start) begin
            // Restart drops whatever is buffered or mid-serialization.
            state_r    <= S_RUN;
            wr_sel_r   <= 1'b0;
            rd_sel_r   <= 1'b0;
            occ_r      <= 2'd0;
            acc_r      <= {(AW+1){1'b0}};
            word_idx_r <= {KW{1'b0}};
            addr_cnt_r <= {AW{1'b0}};
            in_ready   <= in_ready_nxt_s;
            mem_we     <= 1'b0;
            mem_addr   <= {AW{1'b0}};
            busy       <= 1'b1;
            done       <= 1'b0;
            vec_cnt    <= {AW{1'b0}};
`ifdef DCT_WR_CHKSUM_EN
            chksum     <= 16'd0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            busy     <= (state_nxt_s == S_RUN);
            done     <= (state_nxt_s == S_DONE);
            in_ready <= in_ready_nxt_s;
            occ_r    <= occ_nxt_s;
            acc_r    <= acc_nxt_s;
            if (accept_s) begin
                wr_sel_r <= ~wr_sel_r;
            end
            if (ser_we_s) begin
                mem_we     <= 1'b1;
                mem_addr   <= addr_cnt_r;
                mem_wdata  <= word_s;
                addr_cnt_r <= addr_cnt_r + AW'(1'b1);
`ifdef DCT_WR_CHKSUM_EN
                chksum     <= chksum + sext16(word_s);
`endif
                if (last_word_s) begin
                    word_idx_r <= {KW{1'b0}};
                    rd_sel_r   <= ~rd_sel_r;
                    vec_cnt    <= vec_cnt + AW'(1'b1);
                end else begin
                    word_idx_r <= word_idx_r + KW'(1'b1);
                end
            end else begin
                mem_we   <= 1'b0;
                mem_addr <= addr_cnt_r;
            end
        end
    end

endmodule
